// File: rtl/mem_pkg.sv
// Shared widths and FSM state encoding for the data-memory arbiter.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 6;
  localparam int DATA_W_DEFAULT = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ACCESS = 2'd1;
  localparam state_t S_DONE   = 2'd2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: on a tie the port not served last wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic sel
);

  assign valid = req0 | req1;
  assign sel   = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/DONE sequencer in front of the
// 64x16 single-port data memory.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              mem_write,
  output logic              mem_step,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_gnt;
  logic              r_last;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic              w_valid;
  logic              w_sel;

  rr_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (r_last),
    .valid (w_valid),
    .sel   (w_sel)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt    <= 1'b0;
      r_last   <= 1'b1;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (w_valid) r_gnt <= w_sel;
        S_ACCESS: begin
          // Only the granted port's read register moves.
          if (r_gnt) r_rdata1 <= mem_dout;
          else       r_rdata0 <= mem_dout;
        end
        S_DONE:   r_last <= r_gnt;
        default:  ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a value held and infer a latch.
  always_comb begin
    w_next_state = S_IDLE;
    busy         = 1'b0;
    ack0         = 1'b0;
    ack1         = 1'b0;
    mem_step     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_din      = '0;
    case (r_state)
      S_IDLE: w_next_state = w_valid ? S_ACCESS : S_IDLE;
      S_ACCESS: begin
        w_next_state = S_DONE;
        busy         = 1'b1;
        // Gating with reset guarantees no write lands on an aborted access.
        mem_step     = ~reset;
        mem_write    = (r_gnt ? we1 : we0) & ~reset;
        mem_address  = r_gnt ? addr1 : addr0;
        mem_din      = r_gnt ? wdata1 : wdata0;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        busy         = 1'b1;
        ack0         = ~r_gnt & ~reset;
        ack1         = r_gnt & ~reset;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64x16 memory attached.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1, busy, mem_write, mem_step;
  logic [15:0] rdata0, rdata1, mem_din, mem_dout;
  logic [5:0]  mem_address;
  logic        mem_init;
  logic [15:0] mem [64];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(6), .DATA_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0        (req0),
    .req1        (req1),
    .we0         (we0),
    .we1         (we1),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack0        (ack0),
    .ack1        (ack1),
    .rdata0      (rdata0),
    .rdata1      (rdata1),
    .busy        (busy),
    .mem_write   (mem_write),
    .mem_step    (mem_step),
    .mem_address (mem_address),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  // Memory: combinational read, write on the rising edge when step & write.
  assign mem_dout = mem[mem_address];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'(i);
    end else if (mem_step && mem_write) begin
      mem[mem_address] <= mem_din;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_port(input int p, input logic rq, input logic we,
                          input logic [5:0] ad, input logic [15:0] wd);
    if (p == 0) begin
      req0 = rq; we0 = we; addr0 = ad; wdata0 = wd;
    end else begin
      req1 = rq; we1 = we; addr1 = ad; wdata1 = wd;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a0_vec, a1_vec, busy_vec, any_ack;
    int          step_seen;
    reset = 1'b1; mem_init = 1'b1;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (3) tick();
    mem_init = 1'b0;
    reset    = 1'b0;

    // Reset state
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_busy", busy, 0);
    check("rst_step", mem_step, 0);
    check("rst_write", mem_write, 0);
    check("rst_addr", mem_address, 0);
    check("rst_din", mem_din, 0);

    // Port 0 writes BEEF to address 5, then reads it back
    set_port(0, 1, 1, 6'd5, 16'hBEEF);
    tick();
    check("wr_step", mem_step, 1);
    check("wr_write", mem_write, 1);
    check("wr_addr", mem_address, 5);
    check("wr_din", mem_din, 16'hBEEF);
    check("wr_busy", busy, 1);
    check("wr_ack0_early", ack0, 0);
    tick();
    check("wr_ack0", ack0, 1);
    check("wr_ack1", ack1, 0);
    check("wr_step_done", mem_step, 0);
    req0 = 1'b0;
    tick();
    check("wr_idle_busy", busy, 0);
    check("wr_idle_ack0", ack0, 0);
    check("wr_mem5", mem[5], 16'hBEEF);
    set_port(0, 1, 0, 6'd5, 16'h0);
    tick();
    check("rd5_write", mem_write, 0);
    tick();
    check("rd5_ack0", ack0, 1);
    check("rd5_rdata0", rdata0, 16'hBEEF);
    req0 = 1'b0;
    tick();

    // Simultaneous reads from reset: port 0 first, then port 1
    do_reset();
    set_port(0, 1, 0, 6'd1, 16'h0);
    set_port(1, 1, 0, 6'd2, 16'h0);
    tick();
    check("tie_addr_p0", mem_address, 1);
    tick();
    check("tie_ack0", ack0, 1);
    check("tie_ack1_n2", ack1, 0);
    check("tie_rdata0", rdata0, 16'h0001);
    req0 = 1'b0;
    tick();
    check("tie_gap_busy", busy, 0);
    tick();
    check("tie_addr_p1", mem_address, 2);
    tick();
    check("tie_ack1", ack1, 1);
    check("tie_ack0_n5", ack0, 0);
    check("tie_rdata1", rdata1, 16'h0002);
    req1 = 1'b0;
    tick();

    // Both requests held for 12 cycles: strict alternation
    do_reset();
    set_port(0, 1, 0, 6'd3, 16'h0);
    set_port(1, 1, 0, 6'd4, 16'h0);
    a0_vec = '0; a1_vec = '0; busy_vec = '0;
    for (int c = 0; c < 12; c++) begin
      a0_vec[c]   = ack0;
      a1_vec[c]   = ack1;
      busy_vec[c] = busy;
      if (c == 11) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      tick();
    end
    any_ack = a0_vec | a1_vec;
    check("rr_ack0_pattern", a0_vec, 12'h104);
    check("rr_ack1_pattern", a1_vec, 12'h820);
    check("rr_busy_pattern", busy_vec, 12'hDB6);
    check("rr_no_adjacent_ack", any_ack & (any_ack >> 1), 0);
    check("rr_rdata0", rdata0, 16'h0003);
    check("rr_rdata1", rdata1, 16'h0004);

    // Port 1 writes 1234 to address 63 and reads it back; rdata0 untouched
    set_port(1, 1, 1, 6'd63, 16'h1234);
    tick();
    check("p1wr_addr", mem_address, 63);
    check("p1wr_write", mem_write, 1);
    tick();
    check("p1wr_ack1", ack1, 1);
    check("p1wr_rdata0", rdata0, 16'h0003);
    req1 = 1'b0;
    tick();
    set_port(1, 1, 0, 6'd63, 16'h0);
    tick();
    tick();
    check("p1rd_ack1", ack1, 1);
    check("p1rd_rdata1", rdata1, 16'h1234);
    check("p1rd_rdata0", rdata0, 16'h0003);
    req1 = 1'b0;
    tick();

    // Reset during ACCESS of a port-0 write aborts it
    set_port(0, 1, 1, 6'd9, 16'hAAAA);
    tick();
    check("abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    check("abort_step", mem_step, 0);
    check("abort_write", mem_write, 0);
    tick();
    check("abort_ack0", ack0, 0);
    check("abort_idle", busy, 0);
    check("abort_rdata0", rdata0, 0);
    reset = 1'b0;
    req0  = 1'b0;
    tick();
    check("abort_mem9", mem[9], 16'h0009);
    check("abort_step_after", mem_step, 0);

    // req1 dropped during ACCESS still completes
    set_port(1, 1, 0, 6'd7, 16'h0);
    tick();
    req1 = 1'b0;
    tick();
    check("drop_ack1", ack1, 1);
    check("drop_rdata1", rdata1, 16'h0007);
    step_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_step || busy) step_seen++;
    end
    check("drop_idle_after", step_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer for the 64×16 single-port data memory (combinational read; write on `clk` rising edge when `step & write`). Arbitrates between two requesters with round-robin fairness, sequences each access as a fixed three-state transaction, and returns read data with a one-cycle acknowledge. Sits between the control unit (port 0) and the loader/debug path (port 1) on one side, and the memory's `write`/`step`/`address`/`din`/`dout` pins on the other.

## Interface
Parameters:
- `ADDR_W`, 6, memory address width (64 words)
- `DATA_W`, 16, memory word width

Ports:
- `clk`  in  1  system clock, single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req0` / `req1`  in  1  access request, held until matching ack
- `we0` / `we1`  in  1  1 = write, 0 = read; held with req
- `addr0` / `addr1`  in  ADDR_W  word address; held with req
- `wdata0` / `wdata1`  in  DATA_W  write data; held with req
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata0` / `rdata1`  out  DATA_W  registered read data, valid from the ack cycle until that port's next ack
- `busy`  out  1  high in ACCESS and DONE
- `mem_write`  out  1  to memory `write`
- `mem_step`  out  1  to memory `step`
- `mem_address`  out  ADDR_W  to memory `address`
- `mem_din`  out  DATA_W  to memory `din`
- `mem_dout`  in  DATA_W  from memory `dout` (combinational read)

## Operation
- FSM states: IDLE, ACCESS, DONE. Registered `gnt` (0/1) selects the port; registered `last` records the port most recently served.
- IDLE: with no request, stay. With one request, grant it. With both, grant `!last`. Go to ACCESS.
- ACCESS: `mem_step = ~reset`, `mem_write = we[gnt] & ~reset`, `mem_address = addr[gnt]`, `mem_din = wdata[gnt]`. At the clock edge the memory writes (if `we`) and `rdata[gnt] <= mem_dout`. Go to DONE.
- DONE: `ack[gnt] = 1`, `last <= gnt`. Go to IDLE.
- Outside ACCESS: `mem_step = mem_write = 0` and `mem_address = mem_din = 0`.
- A write captures the pre-write word into `rdata[gnt]`, which is don't-care to the requester.
- A request still high in the IDLE cycle after ack is treated as a new request.
- `req` dropped during ACCESS/DONE is ignored; the transaction completes and ack still pulses.
- `rdata` of the non-granted port is never modified.
- Reset values: state IDLE, `gnt = 0`, `last = 1` (port 0 wins the first tie), `ack0 = ack1 = 0`, `rdata0 = rdata1 = 0`, `busy = 0`, all `mem_*` outputs 0.
- Reset mid-transaction aborts it: no memory write occurs in any cycle where `reset` is high, and no ack is issued.

## Timing
- Request seen in IDLE at cycle N: ACCESS at N+1, memory write at the end of N+1, ack and `rdata` valid in N+2, IDLE at N+3.
- Throughput: one access per 3 cycles. Back-to-back on the same port gives acks at N+2, N+5, …
- Under continuous dual requests, grants alternate strictly 0,1,0,1; worst-case wait is 6 cycles.
- `ack0` and `ack1` are mutually exclusive and never high for two consecutive cycles.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults
  - state encoding localparams `S_IDLE = 2'd0`, `S_ACCESS = 2'd1`, `S_DONE = 2'd2`
  - `S_DONE + 1` is illegal and recovers to IDLE
- One sub-module, `rr_pick2`: combinational inputs `req0`, `req1`, `last`; outputs `valid` and `sel`. Instantiated once; the FSM and datapath muxes stay in `mem_arbiter`.

## Test plan
- After reset: all outputs 0. Port 0 writes 16'hBEEF to address 6'd5. Then `mem_step = mem_write = 1` with address 5 for exactly one cycle, `ack0` two cycles after req, and a later port-0 read of address 5 returns `rdata0 = 16'hBEEF`.
- Both ports request reads together from reset (address 1 holds 16'h0001, address 2 holds 16'h0002). Port 0 is served first (`ack0` at N+2, `rdata0 = 16'h0001`), then port 1 (`ack1` at N+5, `rdata1 = 16'h0002`).
- Both `req` held high for 12 cycles: ack order is 0,1,0,1; acks never on adjacent cycles; `busy` low exactly one cycle between transactions.
- Port 1 writes 16'h1234 to address 6'd63, then reads address 63: `rdata1 = 16'h1234`, and `rdata0` is unchanged throughout.
- `reset` asserted during ACCESS of a port-0 write of 16'hAAAA to address 6'd9: `mem_step` stays 0, address 9 keeps its old value, no `ack0`, state IDLE next cycle.
- `req1` dropped during ACCESS: `ack1` still pulses at N+2, then the FSM idles with no further `mem_step`.
